serial_word_receiver: RTL and testbench

- Serial-to-parallel receiver for the 1-bit framed stream produced by a shifter-based transmitter.
- Detects a start bit, shifts in WIDTH data bits, checks the stop bit, then presents the word on a valid/ready parallel interface.
- Sits between the serial link pin and the parallel consumer logic.
- Bit timing comes from an external bit strobe (sin_en); the block does no oversampling.

---
 rtl/serial_word_receiver.sv | 125 ++++++++++++
 tb/tb_serial_word_receiver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// rtl/serial_word_receiver.sv - framed serial-to-parallel word receiver with valid/ready output
// Optional even-parity bit after the data bits: define SERIAL_WORD_RECEIVER_PARITY_EN.
module serial_word_receiver #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun,
   output logic             parity_err,
   input  logic             err_clr
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
      PARITY = 2'd3,
`endif
      STOP   = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
   logic             word_bad;

`ifndef SERIAL_WORD_RECEIVER_PARITY_EN
   assign parity_err = 1'b0;
   assign word_bad   = 1'b0;
`else
   logic par_bad;
   assign word_bad = par_bad;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
         parity_err <= 1'b0;
         par_bad    <= 1'b0;
`endif
      end else begin
         // Clear and handshake come first so that later set/load assignments win.
         if (err_clr) begin
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
            parity_err <= 1'b0;
`endif
         end
         if (dout_valid && dout_ready)
            dout_valid <= 1'b0;

         if (sin_en) begin
            case (state)
               IDLE: begin
                  if (!sin) begin
                     state <= DATA;
                     cnt   <= '0;
                     busy  <= 1'b1;
                  end
               end
               DATA: begin
                  if (MSB_FIRST != 0)
                     shreg <= {shreg[WIDTH-2:0], sin};
                  else
                     shreg <= {sin, shreg[WIDTH-1:1]};
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(WIDTH - 1)) begin
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
               PARITY: begin
                  par_bad <= ^{shreg, sin};
                  if (^{shreg, sin})
                     parity_err <= 1'b1;
                  state <= STOP;
               end
`endif
               STOP: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (!sin) begin
                     frame_err <= 1'b1;
                  end else if (!word_bad) begin
                     if (!dout_valid || dout_ready) begin
                        dout       <= shreg;
                        dout_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_word_receiver.sv
// tb/tb_serial_word_receiver.sv - self-checking bench for serial_word_receiver
// Two instances (MSB-first and LSB-first) share one stimulus stream.
module tb_serial_word_receiver;

   localparam int W = 4;
   localparam int K_IDLE = 0, K_START = 1, K_DATA = 2, K_PAR = 3, K_STOP = 4;

   logic         clk = 1'b0;
   logic         rst, sin, sin_en, dout_ready, err_clr;
   logic [W-1:0] dout_m, dout_l;
   logic         dv_m, dv_l, busy_m, busy_l, fe_m, fe_l, ov_m, ov_l, pe_m, pe_l;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic         exp_valid, exp_busy, exp_fe, exp_ov, exp_pe;
   logic [W-1:0] exp_dm, exp_dl, frame_m, frame_l;
   logic         par_bad;
   int           rdy_mode, stop_rdy, clr_rand, force_clr;

   always #5 clk = ~clk;

   serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .dout(dout_m), .dout_valid(dv_m),
      .dout_ready(dout_ready), .busy(busy_m), .frame_err(fe_m), .overrun(ov_m),
      .parity_err(pe_m), .err_clr(err_clr));

   serial_word_receiver #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .dout(dout_l), .dout_valid(dv_l),
      .dout_ready(dout_ready), .busy(busy_l), .frame_err(fe_l), .overrun(ov_l),
      .parity_err(pe_l), .err_clr(err_clr));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rev(input logic [W-1:0] d);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = d[W-1-i];
      return r;
   endfunction

   task automatic model_reset();
      exp_valid = 0; exp_busy = 0; exp_fe = 0; exp_ov = 0; exp_pe = 0;
      exp_dm = '0; exp_dl = '0;
   endtask

   task automatic check_all(input string tag);
      check({tag, " dv_m"}, 32'(dv_m), 32'(exp_valid));
      check({tag, " dv_l"}, 32'(dv_l), 32'(exp_valid));
      check({tag, " dout_m"}, 32'(dout_m), 32'(exp_dm));
      check({tag, " dout_l"}, 32'(dout_l), 32'(exp_dl));
      check({tag, " busy"}, 32'({busy_m, busy_l}), 32'({exp_busy, exp_busy}));
      check({tag, " frame_err"}, 32'({fe_m, fe_l}), 32'({exp_fe, exp_fe}));
      check({tag, " overrun"}, 32'({ov_m, ov_l}), 32'({exp_ov, exp_ov}));
      check({tag, " parity_err"}, 32'({pe_m, pe_l}), 32'({exp_pe, exp_pe}));
   endtask

   // One clock: drive at negedge, update model at posedge, compare at next negedge.
   task automatic tick(input logic s, input logic en, input int kind);
      logic rdy, clr, load;
      rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode != 0);
      if (kind == K_STOP && en && stop_rdy >= 0) rdy = (stop_rdy != 0);
      clr = (force_clr != 0) || ((clr_rand != 0) && ($urandom_range(0, 7) == 0));
      sin = s; sin_en = en; dout_ready = rdy; err_clr = clr;
      @(posedge clk);
      load = 0;
      if (clr) begin exp_fe = 0; exp_ov = 0; exp_pe = 0; end
      if (en && kind == K_START) exp_busy = 1;
      if (en && kind == K_PAR && par_bad) exp_pe = 1;
      if (en && kind == K_STOP) begin
         exp_busy = 0;
         if (!s) exp_fe = 1;
         else if (!par_bad) begin
            if (!exp_valid || rdy) load = 1;
            else exp_ov = 1;
         end
      end
      if (load) begin exp_valid = 1; exp_dm = frame_m; exp_dl = frame_l; end
      else if (exp_valid && rdy) exp_valid = 0;
      @(negedge clk);
      check_all("tick");
   endtask

   // gap < 0: random 0..3 idle (sin_en=0) cycles before each strobe
   task automatic strobe(input logic s, input int kind, input int gap);
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int i = 0; i < g; i++) tick(1'($urandom_range(0, 1)), 1'b0, K_IDLE);
      tick(s, 1'b1, kind);
   endtask

   task automatic send_frame(input logic [W-1:0] d, input logic stop, input int gap,
                             input logic pflip);
      frame_m = d;
      frame_l = rev(d);
      strobe(1'b0, K_START, gap);
      for (int i = W - 1; i >= 0; i--) strobe(d[i], K_DATA, gap);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
      par_bad = pflip;
      strobe((^d) ^ pflip, K_PAR, gap);
`else
      par_bad = 1'b0;
      if (pflip) ;
`endif
      strobe(stop, K_STOP, gap);
      par_bad = 1'b0;
   endtask

   initial begin
      rdy_mode = 1; stop_rdy = -1; clr_rand = 0; force_clr = 0; par_bad = 0;
      frame_m = '0; frame_l = '0;
      rst = 1; sin = 1; sin_en = 0; dout_ready = 0; err_clr = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all("reset");
      rst = 0;
      tick(1'b1, 1'b1, K_IDLE);

      // MSB-first and LSB-first decode, strobe every cycle
      send_frame(4'b1011, 1'b1, 0, 1'b0);
      check("t1 dout_m", 32'(dout_m), 32'h0000000b);
      check("t1 dout_l", 32'(dout_l), 32'h0000000d);
      check("t1 valid", 32'(dv_m), 32'd1);
      tick(1'b1, 1'b1, K_IDLE);
      check("t1 valid one cycle", 32'(dv_m), 32'd0);

      // strobe every third cycle
      send_frame(4'b1011, 1'b1, 2, 1'b0);
      check("t2 dout_l", 32'(dout_l), 32'h0000000d);
      check("t2 valid", 32'(dv_l), 32'd1);
      tick(1'b1, 1'b1, K_IDLE);

      // overrun while holding register full, then clear, then drain
      rdy_mode = 0;
      send_frame(4'hA, 1'b1, 1, 1'b0);
      send_frame(4'h5, 1'b1, 0, 1'b0);
      check("t3 dout held", 32'(dout_m), 32'h0000000a);
      check("t3 overrun", 32'(ov_m), 32'd1);
      force_clr = 1;
      tick(1'b1, 1'b1, K_IDLE);
      force_clr = 0;
      check("t3 overrun cleared", 32'(ov_m), 32'd0);
      rdy_mode = 1;
      tick(1'b1, 1'b1, K_IDLE);
      check("t3 drained", 32'(dv_m), 32'd0);

      // load and handshake in the same cycle
      rdy_mode = 0;
      send_frame(4'h3, 1'b1, 0, 1'b0);
      stop_rdy = 1;
      send_frame(4'hC, 1'b1, 0, 1'b0);
      stop_rdy = -1;
      check("t4 dout", 32'(dout_m), 32'h0000000c);
      check("t4 valid", 32'(dv_m), 32'd1);
      check("t4 no overrun", 32'(ov_m), 32'd0);
      rdy_mode = 1;
      tick(1'b1, 1'b1, K_IDLE);

      // bad stop bit, then a good frame
      send_frame(4'h6, 1'b0, 0, 1'b0);
      check("t5 frame_err", 32'(fe_m), 32'd1);
      check("t5 no valid", 32'(dv_m), 32'd0);
      check("t5 idle", 32'(busy_m), 32'd0);
      send_frame(4'h9, 1'b1, 1, 1'b0);
      check("t5 dout", 32'(dout_m), 32'h00000009);

      // asynchronous reset mid-frame
      frame_m = 4'hE; frame_l = rev(4'hE);
      strobe(1'b0, K_START, 0);
      strobe(1'b1, K_DATA, 0);
      strobe(1'b1, K_DATA, 0);
      #1 rst = 1;
      model_reset();
      #1 check_all("async reset");
      @(negedge clk);
      check_all("in reset");
      rst = 0;
      tick(1'b1, 1'b1, K_IDLE);
      send_frame(4'hF, 1'b1, 0, 1'b0);
      check("t6 dout", 32'(dout_m), 32'h0000000f);

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
      send_frame(4'h3, 1'b1, 0, 1'b1);
      check("t6 parity_err", 32'(pe_m), 32'd1);
      check("t6 parity discard", 32'(dv_m), 32'd0);
`endif

      // randomized frames, gaps, ready and err_clr against the model
      rdy_mode = 2; clr_rand = 1;
      for (int f = 0; f < 60; f++) begin
         repeat ($urandom_range(0, 2)) tick(1'b1, 1'b1, K_IDLE);
         send_frame(W'($urandom), ($urandom_range(0, 7) != 0), -1,
                    ($urandom_range(0, 5) == 0));
      end
      rdy_mode = 1; clr_rand = 0;
      tick(1'b1, 1'b1, K_IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
